// File: rtl/cail_fft_framer.sv
// cail_fft_framer: slices a free-running I/Q sample stream into fixed-length
// AXI-stream frames for the calibration FFT. A small FWFT FIFO absorbs FFT
// backpressure. If the FIFO overflows, the broken frame is completed with zero
// samples, so the FFT never receives a short frame.
module cail_fft_framer #(
    parameter int BIT_NUM    = 24,
    parameter int FRAME_LEN  = 512,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 SYS_CLK,
    input  logic                 SYS_RSTN,
    input  logic                 frame_en,
    input  logic [BIT_NUM-1:0]   din_i,
    input  logic [BIT_NUM-1:0]   din_q,
    input  logic                 din_valid,
    output logic [2*BIT_NUM-1:0] fft_data_tdata,
    output logic                 fft_tvalid_path,
    output logic                 fft_tlast_path,
    input  logic                 fft_tready_path,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          ovf_cnt,
    output logic                 busy
);

    // Each FIFO entry is {tlast, Q, I}.
    localparam int ENTRY_W = 2 * BIT_NUM + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int IDX_W   = $clog2(FRAME_LEN);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_EMPTY = {CNT_W{1'b0}};
    localparam logic [15:0]      CNT_SAT   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;

    logic [ENTRY_W-1:0]    mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  full_r;
    logic                  valid_r;
    logic [IDX_W-1:0]      wr_idx_r;
    logic [15:0]           frame_cnt_r;
    logic [15:0]           ovf_cnt_r;
    logic                  busy_r;

    logic                  idx_last_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic                  ovf_s;
    logic [ENTRY_W-1:0]    wr_entry_s;
    logic [ENTRY_W-1:0]    head_s;

    // The entry being written closes a frame when the write index reaches the last slot.
    assign idx_last_s = (wr_idx_r == IDX_LAST);

    // FWFT head: the output always shows the oldest stored entry.
    assign head_s  = mem_r[rd_ptr_r];
    assign rd_en_s = valid_r & fft_tready_path;

    assign fft_data_tdata  = head_s[2*BIT_NUM-1:0];
    assign fft_tlast_path  = head_s[2*BIT_NUM];
    assign fft_tvalid_path = valid_r;
    assign frame_cnt       = frame_cnt_r;
    assign ovf_cnt         = ovf_cnt_r;
    assign busy            = busy_r;

    // Framing FSM next state and write requests. Writes are issued only when the FIFO is not full.
    always_comb begin
        state_nxt_s = state_r;
        wr_en_s     = 1'b0;
        wr_entry_s  = {ENTRY_W{1'b0}};
        ovf_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Samples arriving while idle are ignored, even in the cycle framing starts.
                if (frame_en) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (din_valid) begin
                    if (!full_r) begin
                        wr_en_s    = 1'b1;
                        wr_entry_s = {idx_last_s, din_q, din_i};
                        // Clearing frame_en takes effect only once the current frame is closed.
                        if (idx_last_s && !frame_en) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        // Sample lost: the rest of this frame becomes zero padding.
                        ovf_s       = 1'b1;
                        state_nxt_s = ST_PAD;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAD: begin
                // Input is discarded; zeros are stored whenever there is room.
                if (!full_r) begin
                    wr_en_s    = 1'b1;
                    wr_entry_s = {idx_last_s, {(2*BIT_NUM){1'b0}}};
                    if (idx_last_s) begin
                        state_nxt_s = frame_en ? ST_RUN : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PAD;
                    end
                end else begin
                    state_nxt_s = ST_PAD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy after this cycle. A simultaneous read and write leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FSM state register.
    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FIFO storage. Cleared on reset so the output data reads as zero afterwards.
    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    // Read and write pointers wrap naturally modulo the power-of-two depth.
    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy plus registered full and valid flags derived from the next occupancy.
    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            count_r <= CNT_EMPTY;
            full_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            valid_r <= (count_nxt_s != CNT_EMPTY);
        end
    end

    // Position of the next stored entry within its frame. Wraps to 0 after the tlast entry.
    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            wr_idx_r <= {IDX_W{1'b0}};
        end else if (wr_en_s) begin
            wr_idx_r <= idx_last_s ? {IDX_W{1'b0}} : (wr_idx_r + IDX_W'(1));
        end
    end

    // Frames delivered to the FFT. This counter wraps.
    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            frame_cnt_r <= 16'd0;
        end else if (rd_en_s && head_s[2*BIT_NUM]) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    // Overflow events, counted only from RUN. This counter saturates instead of wrapping.
    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            ovf_cnt_r <= 16'd0;
        end else if (ovf_s && (ovf_cnt_r != CNT_SAT)) begin
            ovf_cnt_r <= ovf_cnt_r + 16'd1;
        end
    end

    // Busy while framing is active or data is still waiting in the FIFO.
    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE) || (count_nxt_s != CNT_EMPTY);
        end
    end

endmodule

// File: tb/tb_cail_fft_framer.sv
// Testbench for cail_fft_framer. A queue-based reference model predicts every
// output. Directed phases cover the frame, stall, overflow, stop and reset
// scenarios. A randomized phase follows them.
module tb_cail_fft_framer;

    localparam int BN = 24;
    localparam int FL = 8;
    localparam int FD = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAD  = 2;

    logic            clk       = 1'b0;
    logic            rstn      = 1'b0;
    logic            frame_en  = 1'b0;
    logic            din_valid = 1'b0;
    logic            ready     = 1'b0;
    logic [BN-1:0]   din_i     = '0;
    logic [BN-1:0]   din_q     = '0;
    logic [2*BN-1:0] tdata;
    logic            tvalid;
    logic            tlast;
    logic [15:0]     frame_cnt;
    logic [15:0]     ovf_cnt;
    logic            busy;

    always #5 clk = ~clk;

    cail_fft_framer #(
        .BIT_NUM    (BN),
        .FRAME_LEN  (FL),
        .FIFO_DEPTH (FD)
    ) dut (
        .SYS_CLK         (clk),
        .SYS_RSTN        (rstn),
        .frame_en        (frame_en),
        .din_i           (din_i),
        .din_q           (din_q),
        .din_valid       (din_valid),
        .fft_data_tdata  (tdata),
        .fft_tvalid_path (tvalid),
        .fft_tlast_path  (tlast),
        .fft_tready_path (ready),
        .frame_cnt       (frame_cnt),
        .ovf_cnt         (ovf_cnt),
        .busy            (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue of {tlast, Q, I}, framing mode, position in frame, counters.
    logic [2*BN:0] m_q[$];
    int            m_mode  = M_IDLE;
    int            m_pos   = 0;
    logic [15:0]   m_frames = 16'd0;
    logic [15:0]   m_ovf    = 16'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_mode   = M_IDLE;
        m_pos    = 0;
        m_frames = 16'd0;
        m_ovf    = 16'd0;
    endtask

    // One clock edge of the framer behaviour, using the inputs currently driven.
    task automatic model_step();
        logic [2*BN:0] head;
        bit full;
        bit last;
        full = (m_q.size() == FD);
        last = (m_pos == FL - 1);
        if (m_q.size() != 0 && ready) begin
            head = m_q.pop_front();
            if (head[2*BN]) m_frames = m_frames + 16'd1;
        end
        if (m_mode == M_IDLE) begin
            if (frame_en) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (din_valid) begin
                if (!full) begin
                    m_q.push_back({last, din_q, din_i});
                    m_pos = last ? 0 : m_pos + 1;
                    if (last && !frame_en) m_mode = M_IDLE;
                end else begin
                    if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
                    m_mode = M_PAD;
                end
            end
        end else begin
            if (!full) begin
                m_q.push_back({last, {(2*BN){1'b0}}});
                m_pos = last ? 0 : m_pos + 1;
                if (last) m_mode = frame_en ? M_RUN : M_IDLE;
            end
        end
    endtask

    task automatic check_outputs();
        check("tvalid", 64'(tvalid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("tdata", 64'(tdata), 64'(m_q[0][2*BN-1:0]));
            check("tlast", 64'(tlast), 64'(m_q[0][2*BN]));
        end
        check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
        check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
        check("busy", 64'(busy), 64'((m_mode != M_IDLE) || (m_q.size() != 0)));
    endtask

    // Called at a falling edge: check, drive new inputs, advance model, move to next falling edge.
    task automatic tick(input logic en, input logic v, input logic [BN-1:0] i,
                        input logic [BN-1:0] q, input logic rdy);
        check_outputs();
        frame_en  = en;
        din_valid = v;
        din_i     = i;
        din_q     = q;
        ready     = rdy;
        if (rstn) model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input logic en);
        for (int c = 0; c < 40 && m_q.size() != 0; c++) begin
            tick(en, 1'b0, '0, '0, 1'b1);
        end
        check("drain_done", 64'(tvalid), 64'(0));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_tvalid", 64'(tvalid), 64'(0));
        check("rst_tlast", 64'(tlast), 64'(0));
        check("rst_tdata", 64'(tdata), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        check("rst_ovf_cnt", 64'(ovf_cnt), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        model_reset();
        tick(1'b1, 1'b1, BN'(1), BN'(2), 1'b1);
        tick(1'b1, 1'b1, BN'(3), BN'(4), 1'b1);
        rstn = 1'b1;
    endtask

    initial begin
        int k;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Phase 1: 16 samples I=k, Q=-k with the FFT always ready.
        tick(1'b1, 1'b0, '0, '0, 1'b1);
        for (k = 0; k < 16; k++) tick(1'b1, 1'b1, BN'(k), BN'(-k), 1'b1);
        drain(1'b1);
        check("p1_frames", 64'(frame_cnt), 64'(2));
        check("p1_ovf", 64'(ovf_cnt), 64'(0));

        // Phase 2: ready toggling, samples offered on alternate cycles.
        for (int c = 0; c < 32; c++) begin
            tick(1'b1, (c % 2) == 0, BN'(100 + c), BN'(-(100 + c)), (c % 2) == 1);
        end
        drain(1'b1);
        check("p2_frames", 64'(frame_cnt), 64'(4));
        check("p2_ovf", 64'(ovf_cnt), 64'(0));

        // Phase 3: FFT stalled at frame start, overflow forces zero padding.
        for (int c = 0; c < 5; c++) tick(1'b1, 1'b1, BN'(200 + c), BN'(300 + c), 1'b0);
        for (int c = 0; c < 3; c++) tick(1'b1, 1'b1, BN'(400 + c), BN'(500 + c), 1'b0);
        check("p3_ovf", 64'(ovf_cnt), 64'(1));
        for (int c = 0; c < 24; c++) tick(1'b1, 1'b1, BN'(600 + c), BN'(700 + c), 1'b1);

        // Phase 4: align to a frame boundary, then drop frame_en at sample 3.
        for (int c = 0; c < 40 && !(m_pos == 0 && m_mode == M_RUN); c++) begin
            tick(1'b1, 1'b1, BN'($urandom), BN'($urandom), 1'b1);
        end
        check("p4_aligned", 64'(m_pos), 64'(0));
        for (int s = 0; s < 8; s++) tick(s < 3, 1'b1, BN'(800 + s), BN'(900 + s), 1'b1);
        for (int s = 0; s < 4; s++) tick(1'b0, 1'b1, BN'(950 + s), BN'(960 + s), 1'b1);
        drain(1'b0);
        tick(1'b0, 1'b0, '0, '0, 1'b1);
        check("p4_busy_idle", 64'(busy), 64'(0));

        // Phase 5a: reset in the middle of a stalled frame.
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        for (int s = 0; s < 3; s++) tick(1'b1, 1'b1, BN'(1000 + s), BN'(1100 + s), 1'b0);
        do_reset();
        tick(1'b1, 1'b0, '0, '0, 1'b1);
        for (int s = 0; s < 8; s++) tick(1'b1, 1'b1, BN'(1200 + s), BN'(1300 + s), 1'b1);
        drain(1'b1);
        check("p5a_frames", 64'(frame_cnt), 64'(1));

        // Phase 5b: reset while padding.
        for (int c = 0; c < 20 && m_mode != M_PAD; c++) begin
            tick(1'b1, 1'b1, BN'($urandom), BN'($urandom), 1'b0);
        end
        check("p5b_in_pad", 64'(m_mode), 64'(M_PAD));
        do_reset();
        tick(1'b1, 1'b0, '0, '0, 1'b1);
        for (int s = 0; s < 8; s++) tick(1'b1, 1'b1, BN'(1400 + s), BN'(1500 + s), 1'b1);
        drain(1'b1);
        check("p5b_frames", 64'(frame_cnt), 64'(1));
        check("p5b_ovf", 64'(ovf_cnt), 64'(0));

        // Phase 6: randomized traffic with periodic long stalls.
        for (int c = 0; c < 3000; c++) begin
            logic rdy;
            rdy = ((c % 200) < 20) ? 1'b0 : ($urandom_range(0, 9) < 6);
            tick($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                 BN'($urandom), BN'($urandom), rdy);
        end
        drain(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
